ahb_lite_interconnect: RTL and testbench

Parametrised single-manager AHB-Lite interconnect: address decoder, registered data-phase response mux and built-in default slave, as one block.
- Replaces the fixed 8-way decoder plus mux pair at SoC top.
- Sits between the Cortex-M0 bus master and NUM_SLAVES subordinates (memory, GPIO, UART, timer, SPI, LED, ...).
- Unmapped accesses get a protocol-correct two-cycle ERROR response instead of silently reading zero.

---
 rtl/ahb_lite_interconnect.sv | 184 ++++++++++++++++++
 tb/tb_ahb_lite_interconnect.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_interconnect.sv
// ahb_lite_interconnect: single-manager AHB-Lite decoder, registered response mux and default slave.
// Optional stall watchdog and per-slave masking enabled with `define HREADY_TIMEOUT_EN.
`default_nettype none

module ahb_lite_interconnect #(
  parameter int          NUM_SLAVES     = 6,
  parameter logic [3:0]  MEM_REGION     = 4'h0,
  parameter logic [3:0]  PERIPH_REGION  = 4'h5,
  parameter int          SLOT_LSB       = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic [NUM_SLAVES-1:0]      HSEL,
  input  logic [32*NUM_SLAVES-1:0]   HRDATA_S,
  input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]      HRESP_S,
`ifdef HREADY_TIMEOUT_EN
  output logic                       TIMEOUT,
`endif
  output logic [31:0]                HRDATA,
  output logic                       HREADY,
  output logic                       HRESP
);

  localparam int SLOT_W = ((NUM_SLAVES - 1) > 1) ? $clog2(NUM_SLAVES - 1) : 1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e             state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  ds_q, ds_d;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_ds;
  logic [31:0]           slot_idx;
  logic                  xfer_active;
  logic                  ds_accept;
  logic                  abort;
  logic [NUM_SLAVES-1:0] mask;

  assign xfer_active = HTRANS[1];
  assign slot_idx    = 32'(HADDR[SLOT_LSB +: SLOT_W]) + 32'd1;

  // Address-phase decode; masked slaves fall through to the default slave.
  always_comb begin
    dec_sel = '0;
    dec_ds  = 1'b1;
    if (HADDR[31:28] == MEM_REGION) begin
      dec_sel[0] = 1'b1;
      dec_ds     = 1'b0;
    end else if (HADDR[31:28] == PERIPH_REGION) begin
      for (int i = 1; i < NUM_SLAVES; i++) begin
        if (slot_idx == 32'(i)) begin
          dec_sel[i] = 1'b1;
          dec_ds     = 1'b0;
        end
      end
    end
    if ((dec_sel & mask) != '0) begin
      dec_sel = '0;
      dec_ds  = 1'b1;
    end
  end

  assign HSEL      = dec_sel;
  assign ds_accept = HREADY && xfer_active && dec_ds;

  // Data-phase select and default-slave FSM next state.
  always_comb begin
    sel_d   = sel_q;
    ds_d    = ds_q;
    state_d = state_q;
    if (abort) begin
      sel_d   = '0;
      ds_d    = 1'b1;
      state_d = DS_ERR1;
    end else begin
      if (HREADY) begin
        sel_d = dec_sel;
        ds_d  = dec_ds && xfer_active;
      end
      case (state_q)
        DS_OK:   state_d = ds_accept ? DS_ERR1 : DS_OK;
        DS_ERR1: state_d = DS_ERR2;
        DS_ERR2: state_d = ds_accept ? DS_ERR1 : DS_OK;
        default: state_d = DS_OK;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_OK;
      sel_q   <= '0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ds_q    <= ds_d;
    end
  end

  // Response mux: the default slave owns the bus while in an ERROR sequence.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state_q)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DS_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (sel_q[i]) begin
            HRDATA = HRDATA_S[32*i +: 32];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
          end
        end
      end
    endcase
  end

`ifdef HREADY_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]            cnt_q, cnt_d;
  logic                  timeout_q;
  logic [NUM_SLAVES-1:0] mask_q, mask_d;
  logic                  stall;

  assign stall = (state_q == DS_OK) && (sel_q != '0) && !HREADY;
  assign abort = stall && (cnt_q == TO_LAST);
  assign mask  = mask_q;

  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q & ~HREADYOUT_S;
    if (abort) begin
      cnt_d  = '0;
      mask_d = mask_d | sel_q;
    end else if (HREADY) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      mask_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= abort;
      mask_q    <= mask_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign abort = 1'b0;
  assign mask  = '0;
`endif

  // ds_q mirrors the FSM entry condition and is kept for debug visibility.
  logic unused_bits;
  assign unused_bits = ^{HADDR, HTRANS, ds_q};

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
// Directed self-checking bench for ahb_lite_interconnect (NUM_SLAVES=6, TIMEOUT_CYCLES=4).
`default_nettype none

module tb_ahb_lite_interconnect;

  localparam int NS = 6;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [NS-1:0]   HSEL;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]   HREADYOUT_S;
  logic [NS-1:0]   HRESP_S;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
`ifdef HREADY_TIMEOUT_EN
  logic            TIMEOUT;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_interconnect #(
    .NUM_SLAVES     (NS),
    .MEM_REGION     (4'h0),
    .PERIPH_REGION  (4'h5),
    .SLOT_LSB       (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
`ifdef HREADY_TIMEOUT_EN
    .TIMEOUT     (TIMEOUT),
`endif
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h0;
    HTRANS      = 2'b00;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[32*i +: 32] = 32'hA000_0000 + 32'(i);
    #3;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      32'd0);
    tick();
    tick();
    HRESETn = 1'b1;

    // Zero-wait read from memory slave
    HRDATA_S[31:0] = 32'h1234_5678;
    HADDR  = 32'h0000_0010;
    HTRANS = 2'b10;
    #1 chk("mem_hsel", 32'(HSEL), 32'h01);
    tick();
    HADDR  = 32'h5002_0000;
    HTRANS = 2'b10;
    HREADYOUT_S[3] = 1'b0;
    HRDATA_S[32*3 +: 32] = 32'h3333_3333;
    #1;
    chk("mem_rdata",  HRDATA,      32'h1234_5678);
    chk("mem_hready", 32'(HREADY), 32'd1);
    chk("mem_hresp",  32'(HRESP),  32'd0);
    chk("s3_hsel",    32'(HSEL),   32'h08);
    tick();

    // Slave 3 stalls three cycles; the pending address phase must not be captured
    HADDR = 32'h0000_0020;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s3_stall_hready", 32'(HREADY), 32'd0);
      chk("s3_stall_rdata",  HRDATA,      32'h3333_3333);
      tick();
    end
    HREADYOUT_S[3] = 1'b1;
    #1 chk("s3_done_hready", 32'(HREADY), 32'd1);
    tick();

    // Unmapped NONSEQ back-to-back, then an IDLE to unmapped space
    HADDR  = 32'h7000_0000;
    HTRANS = 2'b10;
    #1;
    chk("switch_rdata", HRDATA,    32'h1234_5678);
    chk("unmap_hsel",   32'(HSEL), 32'h00);
    tick();
    HADDR = 32'h7000_0004;
    #1;
    chk("err1a_hready", 32'(HREADY), 32'd0);
    chk("err1a_hresp",  32'(HRESP),  32'd1);
    chk("err1a_rdata",  HRDATA,      32'd0);
    tick();
    #1;
    chk("err2a_hready", 32'(HREADY), 32'd1);
    chk("err2a_hresp",  32'(HRESP),  32'd1);
    tick();
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b00;
    #1;
    chk("err1b_hready", 32'(HREADY), 32'd0);
    chk("err1b_hresp",  32'(HRESP),  32'd1);
    tick();
    #1;
    chk("err2b_hready", 32'(HREADY), 32'd1);
    chk("err2b_hresp",  32'(HRESP),  32'd1);
    tick();
    #1;
    chk("idle_ds_hready", 32'(HREADY), 32'd1);
    chk("idle_ds_hresp",  32'(HRESP),  32'd0);
    chk("idle_ds_rdata",  HRDATA,      32'd0);

    // Slot boundaries and slave HRESP pass-through
    HADDR = 32'h5005_0000;
    #1 chk("slot_oob_hsel", 32'(HSEL), 32'h00);
    HADDR = 32'h5004_0000;
    #1 chk("slot4_hsel", 32'(HSEL), 32'h20);
    HTRANS = 2'b10;
    HRESP_S[5] = 1'b1;
    tick();
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b00;
    #1;
    chk("s5_rdata", HRDATA,     32'hA000_0005);
    chk("s5_hresp", 32'(HRESP), 32'd1);
    HRESP_S[5] = 1'b0;
    tick();

    // Reset asserted during a slave stall
    HADDR  = 32'h5001_0000;
    HTRANS = 2'b10;
    HREADYOUT_S[2] = 1'b0;
    #1 chk("s2_hsel", 32'(HSEL), 32'h04);
    tick();
    HADDR  = 32'h9000_0000;
    HTRANS = 2'b00;
    #1 chk("s2_stall_hready", 32'(HREADY), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst_hready", 32'(HREADY), 32'd1);
    chk("midrst_hresp",  32'(HRESP),  32'd0);
    chk("midrst_rdata",  HRDATA,      32'd0);
`ifdef HREADY_TIMEOUT_EN
    chk("midrst_timeout", 32'(TIMEOUT), 32'd0);
`endif
    tick();
    HRESETn = 1'b1;
    #1 chk("postrst_hready", 32'(HREADY), 32'd1);
    HREADYOUT_S[2] = 1'b1;
    tick();

`ifdef HREADY_TIMEOUT_EN
    // Watchdog: slave 2 stalls forever, abort after four stall cycles
    HADDR  = 32'h5001_0000;
    HTRANS = 2'b10;
    HREADYOUT_S[2] = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_stall_hready",  32'(HREADY),  32'd0);
      chk("to_stall_timeout", 32'(TIMEOUT), 32'd0);
      tick();
    end
    #1;
    chk("to_pulse",       32'(TIMEOUT), 32'd1);
    chk("to_err1_hready", 32'(HREADY),  32'd0);
    chk("to_err1_hresp",  32'(HRESP),   32'd1);
    chk("to_mask_hsel",   32'(HSEL),    32'h00);
    tick();
    #1;
    chk("to_pulse_end",   32'(TIMEOUT), 32'd0);
    chk("to_err2_hready", 32'(HREADY),  32'd1);
    chk("to_err2_hresp",  32'(HRESP),   32'd1);
    tick();
    #1;
    chk("to_masked_err1_hready", 32'(HREADY), 32'd0);
    chk("to_masked_err1_hresp",  32'(HRESP),  32'd1);
    HADDR  = 32'h0000_0000;
    HTRANS = 2'b00;
    tick();
    #1 chk("to_masked_err2_hresp", 32'(HRESP), 32'd1);
    tick();
    HREADYOUT_S[2] = 1'b1;
    HADDR = 32'h5001_0000;
    #1 chk("to_mask_held_hsel", 32'(HSEL), 32'h00);
    tick();
    #1 chk("to_unmask_hsel", 32'(HSEL), 32'h04);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
